// File: rtl/video_mem_arbiter.sv
// video_mem_arbiter
//   Memory-side responder for the video fetch engine. It shares one
//   synchronous 8-bit RAM port between video fetches and the CPU bus, and
//   video always wins. It also decodes the display soft switches at
//   SW_BASE..SW_BASE+7.
//
// Ports
//   clk_25mhz, reset            clock (posedge); async active-high reset
//   read_mem, vid_addr          video fetch strobe (2-cycle level) and address
//   vid_data                    last fetched video byte, held between fetches
//   cpu_req/we/addr/wdata       CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack          read data and one-cycle completion pulse
//   ram_en/we/addr/wdata        RAM port (combinational from the grant)
//   ram_rdata                   RAM read data, 1-cycle latency
//   text, mix, page2, hires     display mode soft switches
module video_mem_arbiter #(
  parameter logic [15:0] RAM_TOP = 16'hBFFF,
  parameter logic [15:0] SW_BASE = 16'hC050
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        read_mem,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        text,
  output logic        mix,
  output logic        page2,
  output logic        hires
);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_DATA, C_ACK} cpu_state_e;

  cpu_state_e  state_q, state_d;
  logic        read_mem_q;
  logic        tag_q;        // 1: the RAM cycle just issued belonged to video
  logic        cap_ram_q;    // 1: the CPU access in C_DATA is a RAM read
  logic [7:0]  vid_data_q;
  logic [7:0]  cpu_rdata_q;
  logic        text_q, mix_q, page2_q, hires_q;

  logic        vstart;
  logic        cpu_is_ram;
  logic        sw_hit;
  logic [15:0] sw_off;
  logic        cpu_gnt;

  // Only the rising edge of read_mem fetches; the second high cycle is idle.
  assign vstart     = read_mem & ~read_mem_q;
  assign cpu_is_ram = (cpu_addr <= RAM_TOP);
  assign sw_off     = cpu_addr - SW_BASE;
  assign sw_hit     = ~cpu_is_ram && (cpu_addr >= SW_BASE) && (sw_off[15:3] == 13'd0);

  // CPU FSM: next state and grant. Non-RAM addresses never wait for video.
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    case (state_q)
      C_IDLE: if (cpu_req) state_d = C_WAIT;
      C_WAIT: begin
        if (!cpu_is_ram) begin
          state_d = C_DATA;
        end else if (!vstart) begin
          cpu_gnt = 1'b1;
          state_d = C_DATA;
        end
      end
      C_DATA:  state_d = C_ACK;
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // RAM port; video has priority in the same cycle.
  assign ram_en    = ~reset & (vstart | cpu_gnt);
  assign ram_we    = ~reset & cpu_gnt & cpu_we;
  assign ram_addr  = vstart ? vid_addr : cpu_addr;
  assign ram_wdata = cpu_wdata;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q     <= C_IDLE;
      read_mem_q  <= 1'b0;
      tag_q       <= 1'b0;
      cap_ram_q   <= 1'b0;
      vid_data_q  <= 8'h00;
      cpu_rdata_q <= 8'h00;
      text_q      <= 1'b1;
      mix_q       <= 1'b0;
      page2_q     <= 1'b0;
      hires_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_mem_q <= read_mem;
      tag_q      <= vstart;
      cap_ram_q  <= cpu_gnt & ~cpu_we;
      // ram_rdata now carries the data of the cycle the tag recorded.
      if (tag_q) vid_data_q <= ram_rdata;
      if (state_q == C_DATA) cpu_rdata_q <= cap_ram_q ? ram_rdata : 8'h00;
      // Soft switch: bits [2:1] pick the switch, bit 0 is its new value.
      if (state_q == C_WAIT && sw_hit) begin
        case (sw_off[2:1])
          2'd0: text_q  <= sw_off[0];
          2'd1: mix_q   <= sw_off[0];
          2'd2: page2_q <= sw_off[0];
          2'd3: hires_q <= sw_off[0];
        endcase
      end
    end
  end

  assign cpu_ack   = (state_q == C_ACK);
  assign cpu_rdata = cpu_rdata_q;
  assign vid_data  = vid_data_q;
  assign text      = text_q;
  assign mix       = mix_q;
  assign page2     = page2_q;
  assign hires     = hires_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Bench for video_mem_arbiter: directed scenarios followed by random
// concurrent video/CPU traffic, checked every cycle against a
// transaction-level model (shadow memory, latency arithmetic, switch state).
module tb_video_mem_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        read_mem;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        text, mix, page2, hires;

  always #5 clk_25mhz = ~clk_25mhz;

  video_mem_arbiter dut (
    .clk_25mhz(clk_25mhz), .reset(reset),
    .read_mem(read_mem), .vid_addr(vid_addr), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .text(text), .mix(mix), .page2(page2), .hires(hires)
  );

  // Synchronous RAM with 1-cycle read latency; preload copies the shadow.
  logic [7:0] mem    [0:65535];
  logic [7:0] shadow [0:65535];
  logic       preload;

  always @(posedge clk_25mhz) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] <= shadow[i];
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int n_tests, n_fail;
  int cur, vphase, vid_upd, cphase, req_cyc, ack_cyc, sw_upd;
  logic        vstart_m, gnt_m;
  logic [7:0]  exp_vid, vid_next, exp_rd;
  logic [3:0]  sw_exp, sw_next;   // {hires, page2, mix, text}
  logic        v_go, c_go, c_we;
  logic [15:0] v_addr, c_addr;
  logic [7:0]  c_wd;

  function automatic logic is_ram(input logic [15:0] a);
    return a <= 16'hBFFF;
  endfunction

  function automatic logic is_sw(input logic [15:0] a);
    return (a >= 16'hC050) && (a <= 16'hC057);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cur);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, predict, check mid-cycle.
  task automatic cycle();
    logic [15:0] n;
    @(posedge clk_25mhz); #1;
    cur++;
    vstart_m = 1'b0;
    gnt_m    = 1'b0;
    // Video: high for two cycles, then at least one low cycle.
    if (vphase == 0 && v_go) begin
      read_mem = 1'b1; vid_addr = v_addr; vphase = 1; v_go = 1'b0;
      vstart_m = 1'b1; vid_upd = cur + 2; vid_next = shadow[v_addr];
    end else if (vphase == 1) begin
      vphase = 2;
    end else if (vphase == 2) begin
      read_mem = 1'b0; vphase = 0;
    end
    // CPU requester.
    if (cphase == 3) begin
      cpu_req = 1'b0; cphase = 0;
    end else if (cphase == 0 && c_go) begin
      cpu_req = 1'b1; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      req_cyc = cur; cphase = 1; c_go = 1'b0;
    end else if (cphase == 1 && cur > req_cyc) begin
      // A RAM access yields to a fetch starting this cycle and goes next cycle.
      if (!(is_ram(cpu_addr) && vstart_m)) begin
        cphase = 2; ack_cyc = cur + 2; exp_rd = 8'h00;
        if (is_ram(cpu_addr)) begin
          gnt_m = 1'b1;
          if (cpu_we) shadow[cpu_addr] = cpu_wdata;
          else        exp_rd = shadow[cpu_addr];
        end else if (is_sw(cpu_addr)) begin
          n = cpu_addr - 16'hC050;
          sw_next = sw_exp;
          sw_next[n[2:1]] = n[0];
          sw_upd = cur + 1;
        end
      end
    end
    if (cur == vid_upd) exp_vid = vid_next;
    if (cur == sw_upd)  sw_exp  = sw_next;
    @(negedge clk_25mhz);
    check("ram_en", ram_en, vstart_m | gnt_m);
    check("ram_we", ram_we, gnt_m & cpu_we);
    if (vstart_m) check("ram_addr_vid", ram_addr, vid_addr);
    if (gnt_m) begin
      check("ram_addr_cpu", ram_addr, cpu_addr);
      if (cpu_we) check("ram_wdata", ram_wdata, cpu_wdata);
    end
    check("vid_data", vid_data, exp_vid);
    check("switches", {hires, page2, mix, text}, sw_exp);
    check("cpu_ack", cpu_ack, cphase == 2 && cur == ack_cyc);
    if (cphase == 2 && cur == ack_cyc) begin
      check("cpu_rdata", cpu_rdata, exp_rd);
      cphase = 3;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_25mhz); #2;
    reset = 1'b1; cpu_req = 1'b0; read_mem = 1'b1; vid_addr = 16'h0400;
    #1;
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    @(negedge clk_25mhz);
    check("rst_switches", {hires, page2, mix, text}, 4'b0001);
    check("rst_vid_data", vid_data, 8'h00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    @(posedge clk_25mhz); #1;
    read_mem = 1'b0;
    @(negedge clk_25mhz);
    reset = 1'b0;
    vphase = 0; cphase = 0; v_go = 1'b0; c_go = 1'b0;
    exp_vid = 8'h00; sw_exp = 4'b0001; vid_upd = -1; sw_upd = -1;
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d);
    int guard;
    c_we = we; c_addr = a; c_wd = d; c_go = 1'b1;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while ((c_go || cphase != 0) && guard < 20);
    check("cpu_op_timeout", guard < 20, 1'b1);
  endtask

  logic [15:0] odd_addr [6];

  initial begin
    n_tests = 0; n_fail = 0; cur = 0;
    reset = 1'b1; preload = 1'b0;
    read_mem = 1'b0; vid_addr = 16'h0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0; cpu_wdata = 8'h0;
    v_go = 1'b0; c_go = 1'b0; c_we = 1'b0; v_addr = 16'h0; c_addr = 16'h0; c_wd = 8'h0;
    vphase = 0; cphase = 0; vid_upd = -1; sw_upd = -1; req_cyc = 0; ack_cyc = 0;
    exp_vid = 8'h00; vid_next = 8'h00; exp_rd = 8'h00; sw_exp = 4'b0001; sw_next = 4'b0001;
    odd_addr = '{16'hC000, 16'hC04F, 16'hC058, 16'hC800, 16'hFFFF, 16'hBFFF};

    for (int i = 0; i < 65536; i++) shadow[i] = 8'($urandom);
    shadow[16'h0400] = 8'hC1;
    preload = 1'b1;
    @(posedge clk_25mhz); #1;
    preload = 1'b0;

    // 1) reset values
    apply_reset();

    // 2) single video fetch of $0400
    v_addr = 16'h0400; v_go = 1'b1;
    repeat (5) cycle();
    check("vid_c1", vid_data, 8'hC1);

    // 3) CPU write then read back
    cpu_op(1'b1, 16'h2000, 8'h55);
    cpu_op(1'b0, 16'h2000, 8'h00);
    check("rd_2000", cpu_rdata, 8'h55);

    // 4) CPU request and video start in the same cycle
    v_addr = 16'h0400; v_go = 1'b1;
    cpu_op(1'b0, 16'h2000, 8'h00);
    repeat (2) cycle();

    // 5) soft switches and unmapped write
    cpu_op(1'b1, 16'hC050, 8'hFF);
    cpu_op(1'b0, 16'hC057, 8'h00);
    check("sw_text", text, 1'b0);
    check("sw_hires", hires, 1'b1);
    cpu_op(1'b1, 16'hC800, 8'hAA);
    check("no_wr_c800", mem[16'hC800], shadow[16'hC800]);

    // 6) reset while a CPU read sits in its data phase
    c_we = 1'b0; c_addr = 16'h2000; c_go = 1'b1;
    for (int g = 0; g < 10 && cphase != 2; g++) cycle();
    check("reached_grant", cphase, 2);
    apply_reset();
    repeat (3) cycle();
    cpu_op(1'b0, 16'h2000, 8'h00);

    // Random concurrent traffic.
    for (int k = 0; k < 3000; k++) begin
      if (!v_go && $urandom_range(0, 2) == 0) begin
        v_addr = 16'h0400 + 16'($urandom_range(0, 7));
        v_go = 1'b1;
      end
      if (!c_go && cphase == 0 && $urandom_range(0, 1) == 0) begin
        c_we = 1'($urandom);
        c_wd = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       c_addr = 16'h0400 + 16'($urandom_range(0, 7));
          1:       c_addr = 16'h2000 + 16'($urandom_range(0, 7));
          2:       c_addr = 16'hC050 + 16'($urandom_range(0, 7));
          default: c_addr = odd_addr[$urandom_range(0, 5)];
        endcase
        c_go = 1'b1;
      end
      cycle();
    end
    for (int g = 0; g < 20 && (c_go || cphase != 0); g++) cycle();
    check("drain", cphase, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
